// File: rtl/poci_master_if.sv
// poci_master_if: POCI widths package and initiator/completer interface.
package pk_poci;
  localparam int addr_width = 32;
  localparam int data_width = 32;
endpackage

interface if_poci;
  logic [pk_poci::addr_width-1:0] paddr;
  logic                           pwrite;
  logic                           psel;
  logic                           penable;
  logic [pk_poci::data_width-1:0] pwdata;
  logic [pk_poci::data_width-1:0] prdata;
  logic                           pready;
  logic                           pslverr;
  modport n (output paddr, pwrite, psel, penable, pwdata, input prdata, pready, pslverr);
endinterface

// File: rtl/poci_master.sv
// poci_master: single-outstanding POCI initiator bridging a valid/ready host request to SETUP/ACCESS phases.
module poci_master import pk_poci::*; #(
  parameter int TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [addr_width-1:0] req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [data_width-1:0] resp_rdata,
  output logic                  resp_err,
  if_poci.n                     bus
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic done;
  always_comb begin
    done = state == ACCESS && (bus.pready || (TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1)));
    nxt = state == IDLE   ? (req_valid ? SETUP : IDLE) :
          state == SETUP  ? ACCESS :
          state == ACCESS ? (done ? RESP : ACCESS) : IDLE;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    bus.psel = state == SETUP || state == ACCESS;
    bus.penable = state == ACCESS;
  end
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state <= IDLE;
      cnt <= '0;
      bus.paddr <= '0;
      bus.pwrite <= 1'b0;
      bus.pwdata <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= state == ACCESS ? cnt + CW'(!bus.pready) : '0;
      if (state == IDLE && req_valid) begin
        bus.paddr <= req_addr;
        bus.pwrite <= req_write;
        bus.pwdata <= req_wdata;
      end
      // a timeout completes with an error and no data
      if (done) begin
        resp_rdata <= bus.pready && !bus.pwrite ? bus.prdata : '0;
        resp_err <= bus.pready ? bus.pslverr : 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_poci_master.sv
// tb_poci_master: directed and randomized transfers against a per-transfer expectation model with a
// behavioural completer that inserts a chosen number of wait cycles.
module tb_poci_master;
  import pk_poci::*;
  localparam int TO = 4;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [addr_width-1:0] req_addr = '0;
  logic [data_width-1:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err;
  logic [data_width-1:0] resp_rdata;
  int checks = 0;
  int failures = 0;

  if_poci bus();

  poci_master #(.TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus(bus)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One host transfer; the completer holds pready low for wt ACCESS cycles, then raises it.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input int wt, input logic err, input logic [31:0] rd);
    int n, acc, exp_acc;
    bit done;
    logic exp_err;
    logic [31:0] exp_rd;
    exp_acc = (wt + 1 < TO) ? wt + 1 : TO;
    exp_err = (wt >= TO) ? 1'b1 : err;
    exp_rd = (wt >= TO || wr) ? 32'h0 : rd;
    @(negedge pclk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(negedge pclk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 1; acc = 0; done = 0;
    chk("setup_psel", bus.psel, 1);
    chk("setup_penable", bus.penable, 0);
    chk("ready_busy", req_ready, 0);
    while (!done && n < 20) begin
      if (bus.psel && bus.penable) begin
        acc++;
        chk("paddr_stable", bus.paddr, a);
        chk("pwrite_stable", bus.pwrite, wr);
        chk("pwdata_stable", bus.pwdata, wd);
      end
      if (bus.psel && bus.penable && acc > wt) begin
        bus.pready = 1'b1; bus.prdata = rd; bus.pslverr = err;
      end else begin
        bus.pready = (bus.psel && !bus.penable) ? 1'($urandom) : 1'b0;
        bus.prdata = $urandom; bus.pslverr = 1'($urandom);
      end
      @(negedge pclk);
      n++;
      if (resp_valid) done = 1;
    end
    bus.pready = 1'b0;
    chk("resp_seen", done, 1);
    chk("resp_latency", n, 2 + exp_acc);
    chk("access_cycles", acc, exp_acc);
    chk("resp_err", resp_err, exp_err);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_psel", bus.psel, 0);
    chk("resp_penable", bus.penable, 0);
    @(negedge pclk);
    chk("resp_once", resp_valid, 0);
    chk("ready_after", req_ready, 1);
    chk("resp_hold", resp_rdata, exp_rd);
  endtask

  initial begin
    bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rst_ready", req_ready, 1);
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'hFFFF0000);
    xfer(1'b0, 32'h20, 32'h0, 3, 1'b0, 32'h12345678);
    xfer(1'b0, 32'h30, 32'h0, 1, 1'b1, 32'hA5A5A5A5);
    xfer(1'b0, 32'h40, 32'h0, 50, 1'b0, 32'h11111111);
    xfer(1'b0, 32'h44, 32'h0, 3, 1'b0, 32'hCAFEF00D);
    xfer(1'b1, 32'h48, 32'h55AA55AA, 9, 1'b0, 32'h0);
    for (int i = 0; i < 30; i++)
      xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)), 1'($urandom), $urandom);
    // continuous request stream with a zero-wait completer
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h1;
    bus.pready = 1'b1; bus.pslverr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      chk("b2b_ready", req_ready, (i % 4) == 3);
      chk("b2b_resp", resp_valid, (i % 4) == 2);
      chk("b2b_psel", bus.psel, (i % 4) < 2);
      chk("b2b_penable", bus.penable, (i % 4) == 1);
    end
    req_valid = 1'b0; bus.pready = 1'b0;
    @(negedge pclk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h55;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    chk("abort_in_access", bus.penable, 1);
    presetn = 1'b0;
    @(negedge pclk);
    chk("abort_psel", bus.psel, 0);
    chk("abort_penable", bus.penable, 0);
    chk("abort_resp", resp_valid, 0);
    chk("abort_paddr", bus.paddr, 0);
    presetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("abort_no_resp", resp_valid, 0);
      chk("abort_idle_psel", bus.psel, 0);
    end
    xfer(1'b0, 32'h64, 32'h0, 2, 1'b0, 32'h0BADCAFE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/poci_master.md
POCI_MASTER -- requirements
Module: poci_master

Interface
REQ-001 SHALL: parameter TIMEOUT, default 16, ACCESS-phase wait limit in cycles; 0 disables the timeout.
REQ-002 SHALL: addr_width and data_width taken from pk_poci, not parameters.
REQ-003 SHALL: pclk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL: presetn  input  1  synchronous, active-low reset.
REQ-005 SHALL: req_valid  input  1  host request present.
REQ-006 SHALL: req_ready  output  1  host request accepted when req_valid && req_ready.
REQ-007 SHALL: req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL: req_addr  input  addr_width  transfer address.
REQ-009 SHALL: req_wdata  input  data_width  write data.
REQ-010 SHALL: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL: resp_rdata  output  data_width  read data, valid with resp_valid.
REQ-012 SHALL: resp_err  output  1  pslverr or timeout, valid with resp_valid.
REQ-013 SHALL: bus  if_poci.n  --  POCI initiator port (paddr, pwrite, psel, penable, pwdata out; prdata, pready, pslverr in).

Function
REQ-014 SHALL: FSM states IDLE, SETUP, ACCESS, RESP; one transfer in flight at most.
REQ-015 SHALL: req_ready = 1 only in IDLE; no other qualifiers.
REQ-016 SHALL: IDLE, accept -> register req_addr/req_write/req_wdata into paddr/pwrite/pwdata, go to SETUP; otherwise stay.
REQ-017 SHALL: SETUP: psel=1, penable=0; unconditionally to ACCESS next cycle.
REQ-018 SHALL: ACCESS: psel=1, penable=1; stay while pready=0 and no timeout.
REQ-019 SHALL: ACCESS with pready=1 -> capture prdata (reads only; writes capture 0) into resp_rdata, pslverr into resp_err, go to RESP.
REQ-020 SHALL: wait counter clears on entry to ACCESS, increments each ACCESS cycle with pready=0.
REQ-021 SHALL: TIMEOUT>0, counter == TIMEOUT-1 and pready=0 -> resp_err=1, resp_rdata=0, go to RESP; pready same cycle as limit wins (normal completion).
REQ-022 SHALL: RESP: psel=0, penable=0, resp_valid=1 for exactly one cycle; then IDLE.
REQ-023 SHALL: paddr, pwrite, pwdata stable from SETUP through last ACCESS cycle; retain last values in IDLE/RESP.
REQ-024 SHALL: penable=1 never without psel=1; psel never high in IDLE or RESP.
REQ-025 SHALL: zero-wait latency: accept cycle N, psel cycle N+1, penable cycle N+2, resp_valid N+3, req_ready N+4.
REQ-026 SHALL: resp_rdata/resp_err hold until next capture; only meaningful with resp_valid.
REQ-027 SHALL: prdata/pslverr ignored outside ACCESS-with-pready (or timeout).

Reset
REQ-028 SHALL: presetn=0 at a rising edge -> state IDLE, counter 0, all outputs 0 (paddr, pwrite, psel, penable, pwdata, resp_valid, resp_rdata, resp_err); req_ready=1 after reset release.
REQ-029 SHALL: reset mid-transfer (SETUP/ACCESS/RESP) aborts: psel/penable low next cycle, no resp_valid for the aborted transfer.

Verification
REQ-030 SHALL: write 0x10 <- 0xDEADBEEF, pready=1 immediately -> psel N+1, penable N+2, resp_valid N+3 resp_err=0, pwdata stable 0xDEADBEEF.
REQ-031 SHALL: read 0x20, pready held low 3 ACCESS cycles, prdata=0x12345678 -> resp_valid once, resp_rdata=0x12345678, paddr stable throughout.
REQ-032 SHALL: read with pslverr=1 at pready -> resp_err=1 with resp_valid.
REQ-033 SHALL: TIMEOUT=4, pready never -> exactly 4 ACCESS cycles, resp_err=1, resp_rdata=0; pready=1 on 4th cycle -> resp_err=0.
REQ-034 SHALL: req_valid held high continuously -> req_ready pulses once per 4 cycles, back-to-back transfers without overlap.
REQ-035 SHALL: presetn low during ACCESS -> psel=0, penable=0, resp_valid=0 next cycle, next request completes normally.
